shake_absorb_reader: RTL

SHAKE_ABSORB_READER -- requirements
Module: shake_absorb_reader

---
 rtl/shake_absorb_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/shake_absorb_reader.sv
`default_nettype none
// ============================================================================
// Module   : shake_absorb_reader
// Brief    : Reads a message from an AXI-Stream sink into byte-reversed SHAKE
//            lane words, stalls once per rate block for the permutation, and
//            appends a zero pad word on exact word multiples.
//            Optional macro SHAKE_RD_TKEEP_CHECK_EN enables tkeep/tlast checks.
// Revision : 1.0
// ============================================================================
module shake_absorb_reader #(
   parameter int DATA_W      = 64,
   parameter int CNT_W       = 32,
   parameter int PERM_CYCLES = 24
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [CNT_W-1:0]            byte_len,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic [DATA_W-1:0]           s_tdata,
   input  logic [DATA_W/8-1:0]         s_tkeep,
   input  logic                        s_tlast,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   output logic                        out_last,
   output logic [$clog2(DATA_W/8)-1:0] out_bytes,
   output logic                        busy,
   output logic                        err
);
   localparam int                 c_BPW       = DATA_W / 8;
   localparam int                 c_LB        = $clog2(c_BPW);
   localparam int                 c_HC_W      = $clog2(PERM_CYCLES + 1);
   localparam logic [CNT_W-1:0]   c_BPW_C     = CNT_W'(c_BPW);
   localparam logic [CNT_W:0]     c_BPW_X     = (CNT_W+1)'(c_BPW);
   localparam logic [5:0]         c_WORDS_128 = 6'(168 / c_BPW);
   localparam logic [5:0]         c_WORDS_256 = 6'(136 / c_BPW);
   localparam logic [c_HC_W-1:0]  c_HOLD_LAST = c_HC_W'(PERM_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_HOLD = 2'd2,
      ST_PAD  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_rem;
   logic [5:0]          r_wcnt;
   logic [c_HC_W-1:0]   r_hcnt;
   logic                r_mode128;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic                r_out_last;
   logic [c_LB-1:0]     r_out_bytes;
   logic                r_busy;

   logic                w_tready;
   logic                w_hs;
   logic                w_final;
   logic                w_rate_end;
   logic                w_hold_done;
   logic [CNT_W-1:0]    w_rem_dec;
   logic [CNT_W:0]      w_len_ext;
   logic [CNT_W-1:0]    w_rem_init;
   logic [DATA_W-1:0]   w_swap;

   // Exact multiples get one extra word so the pad word always exists; saturate on overflow.
   assign w_len_ext   = {1'b0, byte_len} + ((byte_len[c_LB-1:0] == '0) ? c_BPW_X : '0);
   assign w_rem_init  = w_len_ext[CNT_W] ? '1 : w_len_ext[CNT_W-1:0];

   // remaining == one word means only the pad word is left, so no stream data is taken.
   assign w_tready    = (r_state == ST_READ) && (r_rem != c_BPW_C);
   assign w_hs        = s_tvalid && w_tready;
   assign w_final     = (r_rem <= c_BPW_C);
   assign w_rem_dec   = r_rem - c_BPW_C;
   assign w_rate_end  = (r_wcnt == ((r_mode128 ? c_WORDS_128 : c_WORDS_256) - 6'd1));
   assign w_hold_done = (r_hcnt == c_HOLD_LAST);

   always_comb begin
      w_swap = '0;
      for (int i = 0; i < c_BPW; i++) begin
         w_swap[(c_BPW-1-i)*8 +: 8] = s_tdata[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_READ;
         ST_READ: begin
            if (r_rem == c_BPW_C)             w_next = ST_PAD;
            else if (w_hs) begin
               if (w_final)                   w_next = ST_IDLE;
               else if (w_rate_end)           w_next = ST_HOLD;
               else if (w_rem_dec == c_BPW_C) w_next = ST_PAD;
               else                           w_next = ST_READ;
            end
         end
         ST_HOLD: if (w_hold_done) w_next = (r_rem == c_BPW_C) ? ST_PAD : ST_READ;
         ST_PAD:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem       <= '0;
         r_wcnt      <= '0;
         r_hcnt      <= '0;
         r_mode128   <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_bytes <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_bytes <= '0;
         if (r_out_last) r_busy <= 1'b0;
         if (r_state == ST_IDLE && start) begin
            r_rem     <= w_rem_init;
            r_wcnt    <= '0;
            r_hcnt    <= '0;
            r_mode128 <= mode[0];
            r_busy    <= 1'b1;
         end
         if (w_hs) begin
            r_out_data  <= w_swap;
            r_out_valid <= 1'b1;
            r_out_last  <= w_final;
            r_out_bytes <= w_final ? r_rem[c_LB-1:0] : '0;
            r_rem       <= w_final ? '0 : w_rem_dec;
            r_wcnt      <= w_rate_end ? '0 : r_wcnt + 6'd1;
         end
         if (r_state == ST_HOLD) r_hcnt <= w_hold_done ? '0 : r_hcnt + c_HC_W'(1);
         if (r_state == ST_PAD) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_rem       <= '0;
         end
      end
   end

   assign s_tready  = w_tready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_bytes = r_out_bytes;
   assign busy      = r_busy;

`ifdef SHAKE_RD_TKEEP_CHECK_EN
   logic r_err;
   logic w_last_beat;
   logic w_proto_bad;
   logic w_unused;

   // The last stream beat is the final data word, or the word just before the pad word.
   assign w_last_beat = w_final || (w_rem_dec == c_BPW_C);
   assign w_proto_bad = (!w_final && (s_tkeep != '1)) || (s_tlast != w_last_beat);
   assign w_unused    = mode[1];

   always_ff @(posedge clk) begin
      if (rst)                      r_err <= 1'b0;
      else if (w_hs && w_proto_bad) r_err <= 1'b1;
   end

   assign err = r_err;
`else
   logic w_unused;
   assign w_unused = ^{mode[1], s_tkeep, s_tlast};
   assign err      = 1'b0;
`endif

endmodule
`default_nettype wire
